seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scan controller driving one shared 2-bit segment encoder.
// Optional inter-digit blanking is compiled in with the SEG_SCAN_BLANK_EN macro.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] counts,
  input  logic [3:0] digit_mask,
  output logic [1:0] enc_count,
  output logic [3:0] digit_en_n,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int unsigned TW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2 || BLANK_CYCLES < 1) begin : g_cfg_check
    $error("seg_scan_ctrl: SCAN_DIV must be >= 2 and BLANK_CYCLES >= 1");
  end

`ifdef SEG_SCAN_BLANK_EN
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  typedef enum logic [0:0] {SHOW = 1'b0, BLANK = 1'b1} state_e;
  logic [BW-1:0] bcnt_q, bcnt_d;
`else
  typedef enum logic [0:0] {SHOW = 1'b0} state_e;
`endif

  state_e        state_q, state_d;
  logic          run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    enc_q, enc_d;
  logic [3:0]    en_n_q, en_n_d;
  logic          tick_q, tick_d;
  logic [1:0]    first_idx, nxt_idx;

  function automatic logic [1:0] digit_of(input logic [7:0] c, input logic [1:0] s);
    digit_of = c[{s, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] lit_n(input logic [1:0] s);
    lit_n = ~(4'b0001 << s);
  endfunction

  // Lowest enabled index; used for every fresh start.
  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest = 2'(k);
    end
  endfunction

  // Next enabled index in circular order; falls back to cur when it is the only one.
  function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] c;
    next_en = cur;
    for (int k = 3; k >= 1; k--) begin
      c = cur + 2'(k);
      if (m[c]) next_en = c;
    end
  endfunction

  assign first_idx = lowest(digit_mask);
  assign nxt_idx   = next_en(idx_q, digit_mask);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    enc_d   = enc_q;
    en_n_d  = 4'hF;
    tick_d  = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    if (digit_mask == 4'b0000) begin
      state_d = SHOW;
      run_d   = 1'b0;
      timer_d = '0;
`ifdef SEG_SCAN_BLANK_EN
      bcnt_d  = '0;
`endif
    end else if (!run_q) begin
      state_d = SHOW;
      run_d   = 1'b1;
      timer_d = '0;
      idx_d   = first_idx;
      enc_d   = digit_of(counts, first_idx);
      en_n_d  = lit_n(first_idx);
    end else begin
      case (state_q)
        SHOW: begin
          en_n_d = digit_mask[idx_q] ? lit_n(idx_q) : 4'hF;
          if (timer_q == TW'(SCAN_DIV - 1)) begin
            timer_d = '0;
            idx_d   = nxt_idx;
            tick_d  = (nxt_idx <= idx_q);
`ifdef SEG_SCAN_BLANK_EN
            state_d = BLANK;
            bcnt_d  = '0;
            en_n_d  = 4'hF;
`else
            enc_d   = digit_of(counts, nxt_idx);
            en_n_d  = lit_n(nxt_idx);
`endif
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
`ifdef SEG_SCAN_BLANK_EN
        BLANK: begin
          if (bcnt_q == BW'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            bcnt_d  = '0;
            enc_d   = digit_of(counts, idx_q);
            en_n_d  = digit_mask[idx_q] ? lit_n(idx_q) : 4'hF;
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
          end
        end
`endif
        default: state_d = SHOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW;
      run_q   <= 1'b0;
      timer_q <= '0;
      idx_q   <= 2'd0;
      enc_q   <= 2'd0;
      en_n_q  <= 4'hF;
      tick_q  <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      enc_q   <= enc_d;
      en_n_q  <= en_n_d;
      tick_q  <= tick_d;
`ifdef SEG_SCAN_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign enc_count  = enc_q;
  assign digit_en_n = en_n_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYCLES=2); follows SEG_SCAN_BLANK_EN if defined.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLANK_CYCLES = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int unsigned BL = BLANK_CYCLES;
`else
  localparam int unsigned BL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] counts;
  logic [3:0] digit_mask;
  logic [1:0] enc_count, digit_idx;
  logic [3:0] digit_en_n;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [1:0] enc;
    logic [3:0] en_n;
    logic       tick;
  } exp_t;

  // seq holds six dwell indices, element 0 = first dwell.
  typedef struct packed {
    logic [3:0]      mask;
    logic [7:0]      cnt;
    logic [5:0][1:0] seq;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk(clk), .rst(rst), .counts(counts), .digit_mask(digit_mask),
    .enc_count(enc_count), .digit_en_n(digit_en_n),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] dig(input logic [7:0] c, input logic [1:0] s);
    dig = c[{s, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] lit(input logic [1:0] s);
    lit = ~(4'b0001 << s);
  endfunction

  task automatic push(input logic [1:0] i, input logic [1:0] e, input logic [3:0] n, input logic t);
    exp_t x;
    x.idx = i; x.enc = e; x.en_n = n; x.tick = t;
    q.push_back(x);
  endtask

  task automatic push_dw(input logic [1:0] s, input logic [1:0] e, input logic t);
    push(s, e, lit(s), t);
    for (int c = 1; c < int'(SCAN_DIV); c++) push(s, e, lit(s), 1'b0);
  endtask

  // Advance from prev to nxt: optional blank gap, then a full lit dwell.
  task automatic push_adv(input logic [1:0] prev, input logic [1:0] nxt,
                          input logic [1:0] e_nxt, input logic [1:0] e_prev);
    if (BL == 0) begin
      push_dw(nxt, e_nxt, nxt <= prev);
    end else begin
      push(nxt, e_prev, 4'hF, nxt <= prev);
      for (int b = 1; b < int'(BL); b++) push(nxt, e_prev, 4'hF, 1'b0);
      push_dw(nxt, e_nxt, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scan: expectation queue empty at t=%0t", $time);
      end else begin
        x = q.pop_front();
        if ({digit_idx, enc_count, digit_en_n, frame_tick} !== x) begin
          errors++;
          $display("FAIL scan t=%0t: got idx=%0d enc=%b en_n=%b tick=%b, want idx=%0d enc=%b en_n=%b tick=%b",
                   $time, digit_idx, enc_count, digit_en_n, frame_tick, x.idx, x.enc, x.en_n, x.tick);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({digit_idx, enc_count, digit_en_n, frame_tick} !== {2'd0, 2'd0, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL %s: got idx=%0d enc=%b en_n=%b tick=%b, want idx=0 enc=00 en_n=1111 tick=0",
               nm, digit_idx, enc_count, digit_en_n, frame_tick);
    end
  endtask

  // Park the scan with mask=0000, then present the new mask/counts for the next edge.
  task automatic restart(input logic [3:0] m, input logic [7:0] c);
    digit_mask = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (digit_en_n !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL idle: got en_n=%b tick=%b, want en_n=1111 tick=0", digit_en_n, frame_tick);
    end
    digit_mask = m;
    counts     = c;
  endtask

  initial begin
    vecs[0] = '{mask: 4'b1111, cnt: 8'b11_10_01_00, seq: {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{mask: 4'b0101, cnt: 8'b11_10_01_00, seq: {2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0}};
    vecs[2] = '{mask: 4'b0100, cnt: 8'b00_11_01_10, seq: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[3] = '{mask: 4'b1010, cnt: 8'b01_11_00_10, seq: {2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1}};
    vecs[4] = '{mask: 4'b1001, cnt: 8'b10_00_11_01, seq: {2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0}};
    vecs[5] = '{mask: 4'b0110, cnt: 8'b11_01_10_00, seq: {2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1}};

    rst = 1'b1; digit_mask = 4'b0000; counts = 8'h00;
    @(posedge clk); #1;
    check_reset_vals("reset");
    rst = 1'b0;

    foreach (vecs[v]) begin
      restart(vecs[v].mask, vecs[v].cnt);
      push_dw(vecs[v].seq[0], dig(vecs[v].cnt, vecs[v].seq[0]), 1'b0);
      for (int d = 1; d < 6; d++)
        push_adv(vecs[v].seq[d-1], vecs[v].seq[d],
                 dig(vecs[v].cnt, vecs[v].seq[d]), dig(vecs[v].cnt, vecs[v].seq[d-1]));
      drain(q.size());
    end

    // Single digit, then mask cleared mid-dwell, then re-enabled from zero.
    restart(4'b0100, 8'b00_11_01_10);
    push_dw(2'd2, 2'b11, 1'b0);
    push_adv(2'd2, 2'd2, 2'b11, 2'b11);
    drain(int'(SCAN_DIV + BL) + 2);
    q.delete();
    digit_mask = 4'b0000;
    for (int k = 0; k < 10; k++) push(2'd2, 2'b11, 4'hF, 1'b0);
    drain(q.size());
    digit_mask = 4'b1100;
    counts     = 8'b01_10_00_00;
    push_dw(2'd2, 2'b10, 1'b0);
    push_adv(2'd2, 2'd3, 2'b01, 2'b10);
    push_adv(2'd3, 2'd2, 2'b10, 2'b01);
    drain(q.size());

    // counts for digit 0 change at dwell clock 1; visible only at digit 0's next dwell.
    restart(4'b1111, 8'b11_10_01_00);
    push_dw(2'd0, 2'b00, 1'b0);
    push_adv(2'd0, 2'd1, 2'b01, 2'b00);
    push_adv(2'd1, 2'd2, 2'b10, 2'b01);
    push_adv(2'd2, 2'd3, 2'b11, 2'b10);
    push_adv(2'd3, 2'd0, 2'b11, 2'b11);
    drain(1);
    counts = 8'b11_10_01_11;
    drain(q.size());

    // Digit 1 disabled mid-dwell: dark next clock, dwell still runs to its end.
    restart(4'b1111, 8'b11_10_01_00);
    push_dw(2'd0, 2'b00, 1'b0);
    push_adv(2'd0, 2'd1, 2'b01, 2'b00);
    drain(q.size() - int'(SCAN_DIV) + 1);
    q.delete();
    digit_mask = 4'b1101;
    for (int k = 1; k < int'(SCAN_DIV); k++) push(2'd1, 2'b01, 4'hF, 1'b0);
    push_adv(2'd1, 2'd2, 2'b10, 2'b01);
    push_adv(2'd2, 2'd3, 2'b11, 2'b10);
    push_adv(2'd3, 2'd0, 2'b00, 2'b11);
    drain(q.size());

    // Asynchronous reset at digit 2, timer 2; scan restarts with a full dwell on digit 0.
    restart(4'b1111, 8'b11_10_01_00);
    push_dw(2'd0, 2'b00, 1'b0);
    push_adv(2'd0, 2'd1, 2'b01, 2'b00);
    push_adv(2'd1, 2'd2, 2'b10, 2'b01);
    drain(q.size() - 1);
    q.delete();
    #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    @(posedge clk); #1;
    check_reset_vals("reset_hold");
    rst = 1'b0;
    push_dw(2'd0, 2'b00, 1'b0);
    push_adv(2'd0, 2'd1, 2'b01, 2'b00);
    drain(q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
